// File: rtl/pan_pkg.sv
// pan_pkg: shared definitions for the pan_control block.
//   - Button direction indices into the [6:3] button/btn_held vectors.
//   - Repeat FSM state encoding (also exported on the debug state bus).
//   - Acceleration constants used when PAN_ACCEL_EN is defined.
//   - step_amount(): gates a button's step size with its step request.
package pan_pkg;

    localparam int DIR_UP    = 3;
    localparam int DIR_RIGHT = 4;
    localparam int DIR_DOWN  = 5;
    localparam int DIR_LEFT  = 6;

    localparam int ACCEL_THRESH = 16;
    localparam int ACCEL_STEP   = 4;

    // Wide enough for the largest step size (ACCEL_STEP).
    localparam int STEP_W = 3;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } rep_state_t;

    function automatic logic [STEP_W-1:0] step_amount(input logic              req,
                                                      input logic [STEP_W-1:0] size);
        return req ? size : '0;
    endfunction

endpackage

// File: rtl/pan_control_if.sv
// pan_control_if: signal bundle between the button/timing side and the
// pan_control block.
//   button      raw asynchronous buttons, [3]=up [4]=right [5]=down [6]=left
//   frame_start one-cycle strobe at h_count=0, v_count=0
//   h_shift     horizontal pan offset (registered)
//   v_shift     vertical pan offset (registered)
//   btn_held    debounced button levels (registered)
//   dbg_state   repeat FSM states, 2 bits per button, up in [1:0] .. left in [7:6]
//
// Handshake semantics: there is no valid/ready pair on this bundle.
// frame_start is a qualifier-free strobe: every cycle it is high is one frame
// boundary and is consumed unconditionally; the block can never stall it.
// The outputs are plain registered levels, valid in every cycle after reset.
//
// master: the driving side (buttons, timing generator); slave: pan_control.
interface pan_control_if #(
    parameter int SHIFT_W = 10
);
    logic [6:3]         button;
    logic               frame_start;
    logic [SHIFT_W-1:0] h_shift;
    logic [SHIFT_W-1:0] v_shift;
    logic [6:3]         btn_held;
    logic [7:0]         dbg_state;

    modport master (
        output button,
        output frame_start,
        input  h_shift,
        input  v_shift,
        input  btn_held,
        input  dbg_state
    );

    modport slave (
        input  button,
        input  frame_start,
        output h_shift,
        output v_shift,
        output btn_held,
        output dbg_state
    );
endinterface

// File: rtl/button_debounce.sv
// button_debounce: one pan button, from raw pin to per-frame step request.
//   2-flop synchronizer -> debounce counter -> repeat FSM -> pending step flag.
// Ports:
//   pixel_clk, reset_n  clock and synchronous active-low reset
//   button_raw          raw asynchronous button, active high
//   frame_start         one-cycle frame boundary strobe
//   held                debounced level (registered)
//   step_req            a step is due; meaningful in frame_start cycles
//   step_size           size of this button's step
//   state_dbg           repeat FSM state
// Optional feature: `define PAN_ACCEL_EN enables step acceleration (step size
// ACCEL_STEP after ACCEL_THRESH repeat steps); otherwise the step is always 1.
module button_debounce
    import pan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 4
) (
    input  logic              pixel_clk,
    input  logic              reset_n,
    input  logic              button_raw,
    input  logic              frame_start,
    output logic              held,
    output logic              step_req,
    output logic [STEP_W-1:0] step_size,
    output rep_state_t        state_dbg
);

    localparam int DB_W   = $clog2(DEBOUNCE_CYCLES + 1);
    localparam int F_MAX  = (REPEAT_DELAY > REPEAT_RATE) ? REPEAT_DELAY : REPEAT_RATE;
    localparam int FCNT_W = $clog2(F_MAX + 1);

    logic              sync1_q;
    logic              sync2_q;
    logic [DB_W-1:0]   db_cnt_q;
    logic              held_q;
    rep_state_t        state_q;
    rep_state_t        state_d;
    logic [FCNT_W-1:0] fcnt_q;
    logic [FCNT_W-1:0] fcnt_d;
    logic              set_step;
    logic              pending_q;

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
        end else begin
            sync1_q <= button_raw;
            sync2_q <= sync1_q;
        end
    end

    // The counter only runs while the synced input disagrees with the
    // accepted level, so any bounce back to the old level restarts it.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            db_cnt_q <= '0;
            held_q   <= 1'b0;
        end else if (sync2_q == held_q) begin
            db_cnt_q <= '0;
        end else if (db_cnt_q == DB_W'(DEBOUNCE_CYCLES - 1)) begin
            held_q   <= ~held_q;
            db_cnt_q <= '0;
        end else begin
            db_cnt_q <= db_cnt_q + DB_W'(1);
        end
    end

    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            state_q <= IDLE;
            fcnt_q  <= '0;
        end else begin
            state_q <= state_d;
            fcnt_q  <= fcnt_d;
        end
    end

    // A held button only sits in IDLE for the single cycle after its rising
    // edge, so "held while IDLE" is the press event.
    always_comb begin
        state_d  = state_q;
        fcnt_d   = fcnt_q;
        set_step = 1'b0;
        if (!held_q) begin
            state_d = IDLE;
            fcnt_d  = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    set_step = 1'b1;
                    state_d  = DELAY;
                    fcnt_d   = '0;
                end
                DELAY: begin
                    if (frame_start) begin
                        if (fcnt_q == FCNT_W'(REPEAT_DELAY - 1)) begin
                            set_step = 1'b1;
                            state_d  = REPEAT;
                            fcnt_d   = '0;
                        end else begin
                            fcnt_d = fcnt_q + FCNT_W'(1);
                        end
                    end
                end
                REPEAT: begin
                    if (frame_start) begin
                        if (fcnt_q == FCNT_W'(REPEAT_RATE - 1)) begin
                            set_step = 1'b1;
                            fcnt_d   = '0;
                        end else begin
                            fcnt_d = fcnt_q + FCNT_W'(1);
                        end
                    end
                end
                default: begin
                    state_d = IDLE;
                    fcnt_d  = '0;
                end
            endcase
        end
    end

    // Every frame_start consumes the request, including one raised in the
    // same cycle (it is visible through step_req immediately).
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            pending_q <= 1'b0;
        end else if (frame_start) begin
            pending_q <= 1'b0;
        end else if (set_step) begin
            pending_q <= 1'b1;
        end
    end

    assign step_req  = pending_q | set_step;
    assign held      = held_q;
    assign state_dbg = state_q;

`ifdef PAN_ACCEL_EN
    localparam int ACC_W = $clog2(ACCEL_THRESH + 1);

    logic [ACC_W-1:0] acc_q;

    // Counts steps raised while already in REPEAT; the press step and the
    // DELAY-to-REPEAT step do not count.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            acc_q <= '0;
        end else if (state_q == IDLE) begin
            acc_q <= '0;
        end else if (state_q == REPEAT && set_step && acc_q != ACC_W'(ACCEL_THRESH)) begin
            acc_q <= acc_q + ACC_W'(1);
        end
    end

    assign step_size = (acc_q == ACC_W'(ACCEL_THRESH)) ? STEP_W'(ACCEL_STEP) : STEP_W'(1);
`else
    assign step_size = STEP_W'(1);
`endif

endmodule

// File: rtl/pan_control.sv
// pan_control: debounced, auto-repeating pan buttons driving the VGA pan
// offsets. Offsets move only on frame_start so a frame never tears.
// Ports:
//   pixel_clk  system clock, rising edge
//   reset_n    synchronous active-low reset
//   bus        pan_control_if.slave: button, frame_start in;
//              h_shift, v_shift, btn_held, dbg_state out
// Optional feature: `define PAN_ACCEL_EN for accelerated repeat steps
// (handled inside button_debounce; opposing steps of unequal size leave
// the net difference).
module pan_control
    import pan_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 360000,
    parameter int REPEAT_DELAY    = 30,
    parameter int REPEAT_RATE     = 4,
    parameter int SHIFT_W         = 10
) (
    input  logic         pixel_clk,
    input  logic         reset_n,
    pan_control_if.slave bus
);

    logic [6:3]        held;
    logic [6:3]        step_req;
    logic [STEP_W-1:0] step_size [6:3];
    rep_state_t        rep_state [6:3];

    for (genvar b = DIR_UP; b <= DIR_LEFT; b++) begin : g_btn
        button_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_DELAY   (REPEAT_DELAY),
            .REPEAT_RATE    (REPEAT_RATE)
        ) u_btn (
            .pixel_clk  (pixel_clk),
            .reset_n    (reset_n),
            .button_raw (bus.button[b]),
            .frame_start(bus.frame_start),
            .held       (held[b]),
            .step_req   (step_req[b]),
            .step_size  (step_size[b]),
            .state_dbg  (rep_state[b])
        );
    end

    logic [SHIFT_W-1:0] amt_up;
    logic [SHIFT_W-1:0] amt_right;
    logic [SHIFT_W-1:0] amt_down;
    logic [SHIFT_W-1:0] amt_left;
    logic [SHIFT_W-1:0] h_q;
    logic [SHIFT_W-1:0] v_q;

    assign amt_up    = SHIFT_W'(step_amount(step_req[DIR_UP],    step_size[DIR_UP]));
    assign amt_right = SHIFT_W'(step_amount(step_req[DIR_RIGHT], step_size[DIR_RIGHT]));
    assign amt_down  = SHIFT_W'(step_amount(step_req[DIR_DOWN],  step_size[DIR_DOWN]));
    assign amt_left  = SHIFT_W'(step_amount(step_req[DIR_LEFT],  step_size[DIR_LEFT]));

    // Adding the positive and subtracting the negative amount cancels equal
    // opposing steps and wraps modulo 2^SHIFT_W without extra logic.
    always_ff @(posedge pixel_clk) begin
        if (!reset_n) begin
            h_q <= '0;
            v_q <= '0;
        end else if (bus.frame_start) begin
            h_q <= h_q + amt_right - amt_left;
            v_q <= v_q + amt_down - amt_up;
        end
    end

    assign bus.h_shift   = h_q;
    assign bus.v_shift   = v_q;
    assign bus.btn_held  = held;
    assign bus.dbg_state = {rep_state[DIR_LEFT], rep_state[DIR_DOWN],
                            rep_state[DIR_RIGHT], rep_state[DIR_UP]};

endmodule

// File: tb/tb_pan_control.sv
// tb_pan_control: self-checking bench for pan_control with
// DEBOUNCE_CYCLES=8, REPEAT_DELAY=3, REPEAT_RATE=2, frame_start every 50
// cycles. A frame-level reference model predicts offsets and held levels.
// Build with `define PAN_ACCEL_EN to also exercise acceleration.
module tb_pan_control;

    localparam int DC    = 8;
    localparam int RD    = 3;
    localparam int RR    = 2;
    localparam int W     = 10;
    localparam int FRAME = 50;

    typedef enum int {A_NONE, A_PRESS, A_RELEASE, A_TAP, A_GLITCH} act_t;

    // ---------------- clock / reset ----------------
    logic pixel_clk = 1'b0;
    logic reset_n   = 1'b0;

    always #5 pixel_clk = ~pixel_clk;

    pan_control_if #(.SHIFT_W(W)) bus ();

    pan_control #(
        .DEBOUNCE_CYCLES(DC),
        .REPEAT_DELAY   (RD),
        .REPEAT_RATE    (RR),
        .SHIFT_W        (W)
    ) dut (
        .pixel_clk(pixel_clk),
        .reset_n  (reset_n),
        .bus      (bus)
    );

    // ---------------- scoreboard state ----------------
    int               n_checks = 0;
    int               n_errors = 0;
    logic [2*W-1:0]   exp_q[$];
    act_t             act   [6:3];
    logic             m_lvl [6:3];
    int               m_k   [6:3];
    int               m_rep [6:3];
    int               exp_h;
    int               exp_v;
    int               force_glen;
    int               hold_tab [10] = '{1, 1, 2, 2, 3, 3, 4, 4, 5, 5};

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] want);
        n_checks++;
        if (got !== want) begin
            n_errors++;
            $display("FAIL %s: got %0d, expected %0d", tag, got, want);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(negedge pixel_clk);
    endtask

    function automatic int wrap(input int x);
        return ((x % (1 << W)) + (1 << W)) % (1 << W);
    endfunction

    task automatic model_reset();
        for (int b = 3; b <= 6; b++) begin
            m_lvl[b] = 1'b0;
            m_k[b]   = 0;
            m_rep[b] = 0;
            act[b]   = A_NONE;
        end
        exp_h = 0;
        exp_v = 0;
        exp_q.delete();
    endtask

    task automatic do_reset(input logic [3:0] btns, input int cycles);
        reset_n         = 1'b0;
        bus.button      = btns;
        bus.frame_start = 1'b0;
        repeat (cycles) tick();
        model_reset();
    endtask

    // Frame-level model: the k-th frame of a hold steps on k=1, k=RD and
    // every RR frames after that; a tap gives exactly one step.
    task automatic model_frame();
        int amt [6:3];
        int step;
        int size;
        for (int b = 3; b <= 6; b++) begin
            step = 0;
            size = 1;
            if (act[b] == A_TAP) begin
                step     = 1;
                m_k[b]   = 0;
                m_rep[b] = 0;
            end else if (m_lvl[b]) begin
                m_k[b]++;
                if (m_k[b] == 1) begin
                    step = 1;
                end else if (m_k[b] >= RD && (m_k[b] - RD) % RR == 0) begin
                    step = 1;
`ifdef PAN_ACCEL_EN
                    if (m_k[b] > RD) begin
                        if (m_rep[b] >= 16) size = 4;
                        if (m_rep[b] < 16) m_rep[b]++;
                    end
`endif
                end
            end else begin
                m_k[b]   = 0;
                m_rep[b] = 0;
            end
            amt[b] = step * size;
        end
        exp_h = wrap(exp_h + amt[4] - amt[6]);
        exp_v = wrap(exp_v + amt[5] - amt[3]);
        exp_q.push_back({exp_v[W-1:0], exp_h[W-1:0]});
    endtask

    // One 50-cycle frame period ending with a frame_start pulse. Button
    // edges are confined to cycles 3..41 so debounced edges settle well
    // before the frame boundary.
    task automatic run_frame();
        int             off [6:3];
        int             len [6:3];
        logic [2*W-1:0] e;
        for (int b = 3; b <= 6; b++) begin
            off[b] = $urandom_range(3, 20);
            if (act[b] == A_TAP) len[b] = $urandom_range(10, 14);
            else if (force_glen > 0) len[b] = force_glen;
            else len[b] = $urandom_range(2, 5);
            if (act[b] == A_PRESS)   m_lvl[b] = 1'b1;
            if (act[b] == A_RELEASE) m_lvl[b] = 1'b0;
        end
        for (int t = 1; t <= FRAME; t++) begin
            tick();
            if (t == 2 && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                check("h_shift", 32'(bus.h_shift), 32'(e[W-1:0]));
                check("v_shift", 32'(bus.v_shift), 32'(e[2*W-1:W]));
            end
            if (t == 47)
                check("btn_held", 32'(bus.btn_held),
                      32'({m_lvl[6], m_lvl[5], m_lvl[4], m_lvl[3]}));
            bus.frame_start = (t == FRAME);
            for (int b = 3; b <= 6; b++) begin
                case (act[b])
                    A_PRESS:   if (t == off[b]) bus.button[b] = 1'b1;
                    A_RELEASE: if (t == off[b]) bus.button[b] = 1'b0;
                    A_TAP: begin
                        if (t == off[b]) bus.button[b] = 1'b1;
                        else if (t == off[b] + len[b]) bus.button[b] = 1'b0;
                    end
                    A_GLITCH: begin
                        for (int j = 0; j < 3; j++) begin
                            if (t == off[b] + 8 * j) bus.button[b] = 1'b1;
                            if (t == off[b] + 8 * j + len[b]) bus.button[b] = 1'b0;
                        end
                    end
                    default: ;
                endcase
            end
        end
        model_frame();
        for (int b = 3; b <= 6; b++) act[b] = A_NONE;
    endtask

    task automatic idle_frames(input int n);
        repeat (n) run_frame();
    endtask

    task automatic random_acts();
        int r;
        for (int b = 3; b <= 6; b++) begin
            r = $urandom_range(0, 99);
            if (m_lvl[b]) act[b] = (r < 30) ? A_RELEASE : A_NONE;
            else if (r < 25) act[b] = A_PRESS;
            else if (r < 40) act[b] = A_TAP;
            else if (r < 50) act[b] = A_GLITCH;
            else act[b] = A_NONE;
        end
    endtask

    // ---------------- stimulus ----------------
    initial begin
        force_glen = 0;
        bus.button = 4'h0;
        bus.frame_start = 1'b0;

        // Reset with all buttons held, then release: each counts as a press.
        do_reset(4'hF, 5);
        check("rst_h_shift", 32'(bus.h_shift), 32'd0);
        check("rst_v_shift", 32'(bus.v_shift), 32'd0);
        check("rst_btn_held", 32'(bus.btn_held), 32'd0);
        check("rst_dbg_state", 32'(bus.dbg_state), 32'd0);
        reset_n = 1'b1;
        repeat (DC + 1) tick();
        check("held_before_latency", 32'(bus.btn_held), 32'd0);
        tick();
        check("held_after_latency", 32'(bus.btn_held), 32'hF);
        bus.button = 4'h0;
        repeat (20) tick();
        check("held_released", 32'(bus.btn_held), 32'd0);
        model_reset();
        // All four pending steps cancel in pairs on this frame.
        idle_frames(2);
        check("cancel_h", 32'(bus.h_shift), 32'd0);
        check("cancel_v", 32'(bus.v_shift), 32'd0);

        // Tap right: exactly one step, nothing afterwards.
        act[4] = A_TAP;
        run_frame();
        idle_frames(10);
        check("tap_right", 32'(bus.h_shift), 32'd1);

        // Bounce on up: three 5-cycle pulses never register.
        force_glen = 5;
        act[3] = A_GLITCH;
        run_frame();
        force_glen = 0;
        idle_frames(2);
        check("bounce_v", 32'(bus.v_shift), 32'd0);

        // Hold down for 10 frames.
        for (int i = 1; i <= 11; i++) begin
            if (i == 1) act[5] = A_PRESS;
            if (i == 11) act[5] = A_RELEASE;
            run_frame();
            if (i >= 2) check("hold_down", 32'(bus.v_shift), 32'(hold_tab[i-2]));
        end
        idle_frames(2);

        // Randomized button activity against the model.
        repeat (40) begin
            random_acts();
            run_frame();
        end
        for (int b = 3; b <= 6; b++) if (m_lvl[b]) act[b] = A_RELEASE;
        idle_frames(3);

        // Wrap-around in both directions from reset.
        do_reset(4'h0, 3);
        reset_n = 1'b1;
        tick();
        act[6] = A_TAP;
        run_frame();
        idle_frames(1);
        check("wrap_left", 32'(bus.h_shift), 32'd1023);
        act[4] = A_TAP;
        run_frame();
        idle_frames(1);
        check("wrap_right", 32'(bus.h_shift), 32'd0);

        // Simultaneous up and down press with hold: always cancels.
        act[3] = A_PRESS;
        act[5] = A_PRESS;
        idle_frames(8);
        act[3] = A_RELEASE;
        act[5] = A_RELEASE;
        idle_frames(2);
        check("up_down_cancel", 32'(bus.v_shift), 32'd0);

`ifdef PAN_ACCEL_EN
        // Long right hold: steps grow to 4 after the 16th repeat step.
        act[4] = A_PRESS;
        idle_frames(40);
        act[4] = A_RELEASE;
        idle_frames(2);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
